// File: rtl/dcs_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcs_ctrl_pkg
// Purpose  : Shared types, SEL encodings and width helpers for the DCS
//            select controller.
// Revision : 1.0 - initial release
// ============================================================================
package dcs_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_DWELL  = 2'd3
  } dcs_state_e;

  localparam logic c_sel_clk0 = 1'b0;
  localparam logic c_sel_clk1 = 1'b1;

  // Ceiling on the activity edge threshold; fixes the widest edge counter.
  localparam int c_act_edges_max = 15;
  localparam int c_edge_cnt_w_max = $clog2(c_act_edges_max + 1);

  // Bits needed to hold the value max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcs_act_sync.sv
`default_nettype none
// ============================================================================
// Module   : dcs_act_sync
// Purpose  : Brings an asynchronous divided toggle into the clk domain,
//            detects level changes and counts them up to a saturation limit.
// Revision : 1.0 - initial release
// ============================================================================
module dcs_act_sync
  import dcs_ctrl_pkg::*;
#(
  parameter int ACT_EDGES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  input  logic clr,
  output logic sat
);

  localparam int c_cnt_w = cnt_width(ACT_EDGES);
  localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(ACT_EDGES);

  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  logic               r_edge;
  logic [c_cnt_w-1:0] r_cnt;

  // Two-flop synchronizer followed by a registered any-edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_s1   <= tgl;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_edge <= r_s2 ^ r_s3;
    end
  end

  // Saturating edge counter; a clear wins over a simultaneous edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (r_edge && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Looks one edge ahead so an edge landing on the decision cycle is counted.
  assign sat = (r_cnt == c_max) || (r_edge && (r_cnt == (c_max - 1'b1)));

endmodule
`default_nettype wire

// File: rtl/dcs_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcs_sel_ctrl
// Purpose  : Drives DCS SEL/SELFORCE. Checks both clocks for activity, then
//            performs a glitchless or forced switch, waits out the DCS switch
//            time and enforces a dwell before the next request.
// Revision : 1.0 - initial release
// ============================================================================
module dcs_sel_ctrl
  import dcs_ctrl_pkg::*;
#(
  parameter int   TIMEOUT    = 255,
  parameter int   ACT_EDGES  = 4,
  parameter int   SWITCH_CYC = 16,
  parameter int   DWELL_CYC  = 64,
  parameter logic RESET_SEL  = c_sel_clk0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic act0_tgl,
  input  logic act1_tgl,
  output logic dcs_sel,
  output logic dcs_selforce,
  output logic cur_sel,
  output logic busy,
  output logic done,
  output logic forced,
  output logic err
);

  // One counter serves as window, switch-hold and dwell timer.
  localparam int c_cnt_w = cnt_width(max3(TIMEOUT, SWITCH_CYC, DWELL_CYC));
  localparam logic [c_cnt_w-1:0] c_win_last   = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_sw_last    = c_cnt_w'(SWITCH_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL_CYC);

  dcs_state_e         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_tgt;
  logic               r_force;
  logic               r_req_ready;
  logic               r_dcs_sel;
  logic               r_dcs_selforce;
  logic               r_cur_sel;
  logic               r_busy;
  logic               r_done;
  logic               r_forced;
  logic               r_err;

  logic w_accept;
  logic w_clr;
  logic w_sat0;
  logic w_sat1;
  logic w_tgt_sat;

  assign w_accept  = (r_state == ST_IDLE) && r_req_ready && req_valid;
  assign w_clr     = w_accept && (req_sel != r_cur_sel);
  assign w_tgt_sat = r_tgt ? w_sat1 : w_sat0;

  dcs_act_sync #(.ACT_EDGES(ACT_EDGES)) u_act0 (
    .clk (clk),
    .rst (rst),
    .tgl (act0_tgl),
    .clr (w_clr),
    .sat (w_sat0)
  );

  dcs_act_sync #(.ACT_EDGES(ACT_EDGES)) u_act1 (
    .clk (clk),
    .rst (rst),
    .tgl (act1_tgl),
    .clr (w_clr),
    .sat (w_sat1)
  );

  // Control FSM with the shared timer and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_tgt          <= RESET_SEL;
      r_force        <= 1'b0;
      r_req_ready    <= 1'b0;
      r_dcs_sel      <= RESET_SEL;
      r_dcs_selforce <= 1'b0;
      r_cur_sel      <= RESET_SEL;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_forced       <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_forced <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            if (req_sel == r_cur_sel) begin
              // Already on the requested input: acknowledge without work.
              r_done <= 1'b1;
            end else begin
              r_tgt       <= req_sel;
              r_cnt       <= '0;
              r_busy      <= 1'b1;
              r_req_ready <= 1'b0;
              r_state     <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (w_sat0 && w_sat1) begin
            r_dcs_sel      <= r_tgt;
            r_dcs_selforce <= 1'b0;
            r_force        <= 1'b0;
            r_cnt          <= '0;
            r_state        <= ST_SWITCH;
          end else if (r_cnt == c_win_last) begin
            if (!w_tgt_sat) begin
              // Target is dead: abort, selection untouched.
              r_err   <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_DWELL;
            end else begin
              // Target alive but current dead: glitchless handoff would stall.
              r_dcs_sel      <= r_tgt;
              r_dcs_selforce <= 1'b1;
              r_force        <= 1'b1;
              r_cnt          <= '0;
              r_state        <= ST_SWITCH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SWITCH: begin
          if (r_cnt == c_sw_last) begin
            r_dcs_selforce <= 1'b0;
            r_cur_sel      <= r_tgt;
            r_done         <= 1'b1;
            r_forced       <= r_force;
            r_cnt          <= '0;
            r_state        <= ST_DWELL;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DWELL: begin
          if (r_cnt == c_dwell_last) begin
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign dcs_sel      = r_dcs_sel;
  assign dcs_selforce = r_dcs_selforce;
  assign cur_sel      = r_cur_sel;
  assign busy         = r_busy;
  assign done         = r_done;
  assign forced       = r_forced;
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dcs_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcs_sel_ctrl
// Purpose  : Directed scoreboard bench for dcs_sel_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcs_sel_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic act0_tgl = 1'b0;
  logic act1_tgl = 1'b0;
  logic req_ready, dcs_sel, dcs_selforce, cur_sel, busy, done, forced, err;

  bit en0 = 1'b0;
  bit en1 = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic is_err;
    logic frc;
    logic sel;
    int   cyc;
  } exp_t;

  exp_t q[$];

  dcs_sel_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .req_ready    (req_ready),
    .act0_tgl     (act0_tgl),
    .act1_tgl     (act1_tgl),
    .dcs_sel      (dcs_sel),
    .dcs_selforce (dcs_selforce),
    .cur_sel      (cur_sel),
    .busy         (busy),
    .done         (done),
    .forced       (forced),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divided toggles: one edge every 4 clk when enabled, off-edge phase.
  initial begin
    int t;
    t = 0;
    forever begin
      @(posedge clk);
      #2;
      t++;
      if (t % 4 == 0) begin
        if (en0) act0_tgl = ~act0_tgl;
        if (en1) act1_tgl = ~act1_tgl;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/err pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done && err) chk("done_err_exclusive", 1, 0);
      if (done || err) begin
        if (q.size() == 0) begin
          chk("unexpected_response", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_err", int'(err), int'(e.is_err));
          chk("sb_forced", int'(forced), int'(e.frc));
          chk("sb_cur_sel", int'(cur_sel), int'(e.sel));
          if (e.cyc >= 0) chk("sb_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic push(input logic is_err, input logic frc, input logic sel, input int c);
    exp_t e;
    e.is_err = is_err;
    e.frc = frc;
    e.sel = sel;
    e.cyc = c;
    q.push_back(e);
  endtask

  // Waits for req_ready, presents a request for one accepting edge.
  task automatic issue(input logic s, output int ca);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("issue_ready_timeout", 0, 1);
    req_valid = 1'b1;
    req_sel = s;
    @(posedge clk);
    #1;
    ca = cyc;
    req_valid = 1'b0;
  endtask

  // Returns the cycle of the next done/err pulse.
  task automatic wait_resp(output int c);
    int n;
    n = 0;
    c = -1;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (done || err) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("resp_timeout", 0, 1);
  endtask

  // Cycles from the current one until req_ready is observed high.
  task automatic cycles_to_ready(output int n);
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (req_ready) break;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dcs_sel", int'(dcs_sel), 0);
    chk("rst_cur_sel", int'(cur_sel), 0);
    chk("rst_flags", int'({dcs_selforce, done, forced, err, busy, req_ready}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(req_ready), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca, r, d, n, nsf, bad_sel, ndone;
    do_reset();

    // Glitchless 0->1 with both clocks alive.
    en0 = 1'b1;
    en1 = 1'b1;
    repeat (10) @(negedge clk);
    issue(1'b1, ca);
    push(1'b0, 1'b0, 1'b1, -1);
    r = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dcs_sel) begin
        r = cyc;
        break;
      end
    end
    chk("alive_rise_window", int'(r - ca >= 5 && r - ca <= 40), 1);
    chk("alive_no_force", int'(dcs_selforce), 0);
    wait_resp(d);
    chk("alive_hold_len", d - r, 16);
    cycles_to_ready(n);
    chk("alive_ready_gap", n, 65);

    // No-op request on the current selection.
    issue(1'b1, ca);
    push(1'b0, 1'b0, 1'b1, ca);
    chk("noop_busy", int'(busy), 0);
    repeat (3) begin
      @(negedge clk);
      chk("noop_idle", int'({busy, dcs_sel}), 1);
    end

    // req_valid held high across a whole 1->0 switch.
    @(negedge clk);
    req_valid = 1'b1;
    req_sel = 1'b0;
    while (!req_ready) @(negedge clk);
    @(posedge clk);
    #1;
    push(1'b0, 1'b0, 1'b0, -1);
    ndone = 0;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (done) ndone++;
      if (req_ready) break;
    end
    req_valid = 1'b0;
    chk("held_single_done", ndone, 1);
    chk("held_cur_sel", int'(cur_sel), 0);
    chk("held_full_cycle", int'(n > 16 + 64), 1);

    // Target clock dead: abort after the full window.
    en1 = 1'b0;
    repeat (10) @(negedge clk);
    issue(1'b1, ca);
    push(1'b1, 1'b0, 1'b0, ca + 255);
    nsf = 0;
    bad_sel = 0;
    d = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dcs_selforce) nsf++;
      if (dcs_sel) bad_sel++;
      if (err || done) begin
        d = cyc;
        break;
      end
    end
    chk("dead_err_cycle", d - ca, 255);
    chk("dead_no_force", nsf, 0);
    chk("dead_sel_kept", bad_sel, 0);
    cycles_to_ready(n);
    chk("dead_ready_gap", n, 65);

    // Current clock dead, target alive: forced switch after the window.
    en0 = 1'b0;
    en1 = 1'b1;
    repeat (10) @(negedge clk);
    issue(1'b1, ca);
    push(1'b0, 1'b1, 1'b1, ca + 271);
    nsf = 0;
    bad_sel = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dcs_selforce) begin
        nsf++;
        if (!dcs_sel) bad_sel++;
      end
      if (done || err) break;
    end
    chk("force_len", nsf, 16);
    chk("force_with_sel", bad_sel, 0);
    chk("force_sel_after", int'({dcs_sel, dcs_selforce}), 2);
    cycles_to_ready(n);

    // Reset pulsed in the middle of a 0->1 switch.
    do_reset();
    en0 = 1'b1;
    en1 = 1'b1;
    repeat (10) @(negedge clk);
    issue(1'b1, ca);
    r = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dcs_sel) begin
        r = cyc;
        break;
      end
    end
    chk("rstmid_switch_seen", int'(r >= 0), 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_sel", int'({dcs_sel, dcs_selforce}), 0);
    chk("rstmid_busy_ready", int'({busy, req_ready}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_ready", int'(req_ready), 1);
    chk("rstmid_cur", int'(cur_sel), 0);
    repeat (30) @(negedge clk);
    chk("rstmid_sel_after", int'(dcs_sel), 0);

    repeat (5) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcs_sel_ctrl.md
# dcs_sel_ctrl

Synchronous controller that drives the SEL and SELFORCE inputs of a DCS (dynamic clock select) primitive. It accepts clock-switch requests over a valid/ready handshake and verifies that both clocks are toggling before switching. It chooses a glitchless or forced switch, holds off for the DCS switch time, and enforces a minimum dwell before accepting the next request. It runs in a free-running system clock domain, independent of the two clocks being muxed.

## Interface
- `TIMEOUT`, 255: length of the activity-check window, in clk cycles (≥ 8).
- `ACT_EDGES`, 4: toggle edges required to declare a clock alive (1..15).
- `SWITCH_CYC`, 16: cycles SEL is held before the switch counts as complete (≥ 1).
- `DWELL_CYC`, 64: minimum cycles after completion before the next request is accepted (≥ 0).
- `RESET_SEL`, 1'b0: DCS input selected out of reset.
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: switch request.
- `req_sel`, in, 1: requested DCS input (0 = CLK0, 1 = CLK1).
- `req_ready`, out, 1: request accepted when `req_valid & req_ready`.
- `act0_tgl`, in, 1: divided toggle from CLK0's domain; asynchronous.
- `act1_tgl`, in, 1: divided toggle from CLK1's domain; asynchronous.
- `dcs_sel`, out, 1: to DCS SEL.
- `dcs_selforce`, out, 1: to DCS SELFORCE.
- `cur_sel`, out, 1: committed selection.
- `busy`, out, 1: high whenever the state is not IDLE.
- `done`, out, 1: one-cycle pulse when a request completes.
- `forced`, out, 1: qualifies `done`; set when the completed switch used SELFORCE.
- `err`, out, 1: one-cycle pulse when a request is aborted because the target clock is dead.

## Operation
- Reset values:
  - All outputs are registered.
  - `dcs_sel` = `cur_sel` = RESET_SEL.
  - `dcs_selforce`, `done`, `forced`, `err`, `busy`, `req_ready` = 0.
  - State = IDLE.
- States: IDLE, CHECK, SWITCH, DWELL.
- IDLE:
  - `req_ready` = 1.
  - On accept with `req_sel == cur_sel`: `done` pulses next cycle with `forced` = 0, and the state stays IDLE (no-op).
  - On accept otherwise: latch the target, clear the edge counters and window counter, go to CHECK.
- CHECK:
  - Each `actN_tgl` passes through a 2-flop synchronizer and an edge detector. Any level change counts as one edge.
  - Per-clock edge counters saturate at ACT_EDGES.
  - The window counter increments once per cycle.
  - Exit early to SWITCH (glitchless) when both counters are saturated.
  - At window == TIMEOUT-1, if the target counter is not saturated: pulse `err`, go to DWELL, leave `dcs_sel` and `cur_sel` unchanged.
  - At window == TIMEOUT-1, if the target is saturated but the current is not: go to SWITCH with force = 1.
  - The target check takes precedence over the current check.
- SWITCH:
  - On entry, `dcs_sel` = target and `dcs_selforce` = force.
  - Both are held for exactly SWITCH_CYC cycles.
  - On the last cycle: `dcs_selforce` returns to 0, `cur_sel` = target, `done` pulses, `forced` = force. Then go to DWELL.
- DWELL: count DWELL_CYC cycles, then return to IDLE. DWELL_CYC = 0 means a direct return to IDLE.
- `req_valid` outside IDLE is ignored. `req_ready` = 0, so no queueing.
- Simultaneous events:
  - Edges arriving on the same cycle as the window expiry are counted before the expiry decision.
  - `done` and `err` are never both high.
- Reset asserted mid-operation (any state) returns all outputs to their reset values immediately. SEL returns to RESET_SEL. No partial state survives.

## Timing
- A toggle edge at `actN_tgl` is reflected in its edge counter 3 clk cycles later: 2 synchronizer stages plus 1 edge register.
- `req_ready` rises on the first clk edge after `rst` deasserts.
- Accept at edge T: CHECK is active from T+1.
- Minimum latency from accept to `done`:
  - With both clocks alive and early exit at CHECK cycle k: `done` is high during cycle T+1+k+SWITCH_CYC.
  - No-op request: `done` at T+1.
- Abort: `err` is high during the cycle after window == TIMEOUT-1, i.e. T+1+TIMEOUT.
- The next `req_ready` rises DWELL_CYC+1 cycles after `done` or `err`.
- Counter widths are $clog2(max+1) of their parameters. No counter wraps; all saturate or are cleared.

## Structure
- Package `dcs_ctrl_pkg`:
  - state enum `dcs_state_e`;
  - localparams for counter widths;
  - constants for encoding SEL0/SEL1.
- Sub-module `dcs_act_sync`: 2-flop synchronizer plus edge detector with a saturating counter, clear input and saturated flag. Instantiated twice.
- Top: FSM, window/switch/dwell counter (one shared, reloaded per state), output registers.

## Test plan
- Both toggles running at 1 edge per 4 clk; request 0→1 -> `dcs_sel` rises at T+1+k, `done` after 16 cycles, `forced` = 0, `cur_sel` = 1, `req_ready` returns 65 cycles after `done`.
- `act1_tgl` stuck; request 0→1 -> `err` at T+256, `dcs_sel` stays 0, `dcs_selforce` never asserts.
- `act0_tgl` stuck, `act1_tgl` alive; request 0→1 -> `dcs_selforce` = 1 for exactly 16 cycles alongside `dcs_sel` = 1, then `done` with `forced` = 1.
- Request equal to `cur_sel` -> `done` one cycle later, `busy` never asserts, SEL unchanged.
- `req_valid` held high continuously through CHECK, SWITCH and DWELL -> exactly one request accepted per IDLE visit.
- `rst` pulsed during SWITCH after a 0→1 switch began -> `dcs_sel` = 0 and `dcs_selforce` = 0 immediately, no `done`, `req_ready` = 1 one cycle after release.
